// File: rtl/aes_uart_dec_ctrl.sv
// Byte sequencer between a UART and an AES-128 decryption core: collects key and
// ciphertext bytes, strobes the core, then streams the plaintext back out byte by byte.
module aes_uart_dec_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    output logic [0:127] key,
    output logic [0:127] data,
    output logic         rx_state,
    input  logic [0:127] decrypted_data,
    input  logic         decrypted_data_state,
    output logic [7:0]   tx_byte,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic         key_loaded,
    output logic         busy,
    output logic         rx_overrun
);

    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_LOAD_KEY,
        S_LOAD_DATA,
        S_START,
        S_WAIT_DEC,
        S_SEND,
        S_SEND_WAIT
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  idle_q, idle_d;
    logic [0:127] key_q, key_d;
    logic [0:127] data_q, data_d;
    logic [0:127] pt_q, pt_d;
    logic         key_loaded_q, key_loaded_d;
    logic         guard_q, guard_d;
    logic         overrun_q, overrun_d;
    logic         busy_w;
    logic [7:0]   pt_lane [16];

    // Byte lane k occupies bits [8k : 8k+7]; lane 0 is the first byte on the wire.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign pt_lane[gi] = pt_q[8*gi +: 8];
        end
    endgenerate

    assign busy_w = (state_q == S_START) || (state_q == S_WAIT_DEC) ||
                    (state_q == S_SEND)  || (state_q == S_SEND_WAIT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idle_d       = '0;
        key_d        = key_q;
        data_d       = data_q;
        pt_d         = pt_q;
        key_loaded_d = key_loaded_q;
        guard_d      = 1'b0;
        overrun_d    = rx_valid && busy_w;
        rx_state     = 1'b0;
        tx_start     = 1'b0;
        tx_byte      = 8'h00;

        case (state_q)
            S_LOAD_KEY, S_LOAD_DATA: begin
                if (rx_valid) begin
                    if (state_q == S_LOAD_KEY) key_d[{cnt_q, 3'b000} +: 8] = rx_byte;
                    else                       data_d[{cnt_q, 3'b000} +: 8] = rx_byte;
                    if (cnt_q == 4'd15) begin
                        cnt_d = 4'd0;
                        if (state_q == S_LOAD_KEY) begin
                            key_loaded_d = 1'b1;
                            state_d      = S_LOAD_DATA;
                        end else begin
                            state_d = S_START;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (TO_EN && cnt_q != 4'd0) begin
                    // Partial block abandoned: restart lane numbering, keep stale lanes.
                    if (idle_q + 32'd1 == TO_LIMIT) cnt_d = 4'd0;
                    else                           idle_d = idle_q + 32'd1;
                end
            end
            S_START: begin
                rx_state = 1'b1;
                state_d  = S_WAIT_DEC;
            end
            S_WAIT_DEC: begin
                if (decrypted_data_state) begin
                    pt_d    = decrypted_data;
                    cnt_d   = 4'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tx_byte  = pt_lane[cnt_q];
                    guard_d  = 1'b1;
                    state_d  = S_SEND_WAIT;
                end
            end
            S_SEND_WAIT: begin
                // The transmitter may not raise tx_busy until a cycle after tx_start.
                if (!guard_q && !tx_busy) begin
                    if (cnt_q == 4'd15) begin
                        cnt_d   = 4'd0;
                        state_d = S_LOAD_DATA;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_LOAD_KEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD_KEY;
            cnt_q        <= '0;
            idle_q       <= '0;
            key_q        <= '0;
            data_q       <= '0;
            pt_q         <= '0;
            key_loaded_q <= 1'b0;
            guard_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            key_q        <= key_d;
            data_q       <= data_d;
            pt_q         <= pt_d;
            key_loaded_q <= key_loaded_d;
            guard_q      <= guard_d;
            overrun_q    <= overrun_d;
        end
    end

    assign key        = key_q;
    assign data       = data_q;
    assign key_loaded = key_loaded_q;
    assign busy       = busy_w;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_aes_uart_dec_ctrl.sv
// Scoreboard bench for aes_uart_dec_ctrl with stub AES core and stub UART transmitter.
module tb_aes_uart_dec_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [0:127] key;
    logic [0:127] data;
    logic         rx_state;
    logic [0:127] decrypted_data;
    logic         decrypted_data_state;
    logic [7:0]   tx_byte;
    logic         tx_start;
    logic         tx_busy;
    logic         key_loaded;
    logic         busy;
    logic         rx_overrun;

    localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_uart_dec_ctrl #(.TIMEOUT_CYCLES(20)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_byte              (rx_byte),
        .rx_valid             (rx_valid),
        .key                  (key),
        .data                 (data),
        .rx_state             (rx_state),
        .decrypted_data       (decrypted_data),
        .decrypted_data_state (decrypted_data_state),
        .tx_byte              (tx_byte),
        .tx_start             (tx_start),
        .tx_busy              (tx_busy),
        .key_loaded           (key_loaded),
        .busy                 (busy),
        .rx_overrun           (rx_overrun)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    int         busy_len = 2;
    int         core_lat = 1;
    int         n_rx_state = 0;
    int         n_overrun = 0;
    int         n_tx = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // UART transmitter stub: busy for busy_len cycles starting the cycle after tx_start.
    initial begin : tx_stub
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // AES core stub: knows only the FIPS-197 vector; anything else yields 0xEE bytes.
    initial begin : core_stub
        decrypted_data_state = 1'b0;
        decrypted_data       = '0;
        forever begin
            @(negedge clk);
            if (rx_state) begin
                repeat (core_lat) @(posedge clk);
                #1;
                decrypted_data = (key === FIPS_KEY && data === FIPS_CT) ? FIPS_PT : {16{8'hEE}};
                decrypted_data_state = 1'b1;
                @(posedge clk);
                #1 decrypted_data_state = 1'b0;
                decrypted_data = '0;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_start and checks pulse rules.
    initial begin : monitor
        logic prev_tx, prev_rs, prev_ov, prev_busy;
        int   cyc, last_tx;
        prev_tx = 1'b0; prev_rs = 1'b0; prev_ov = 1'b0; prev_busy = 1'b0;
        cyc = 0; last_tx = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                n_tx++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %h required no tx_start", tx_byte);
                end else begin
                    $display("tx byte %0d = %h", n_tx, tx_byte);
                    check("tx_byte", {120'd0, tx_byte}, {120'd0, exp_q.pop_front()});
                end
                check("tx_after_busy_low", {127'd0, prev_busy}, 128'd0);
                check("tx_spacing_ge3", {127'd0, (cyc - last_tx) >= 3}, 128'd1);
                last_tx = cyc;
            end
            if (tx_start) check("tx_start_single", {127'd0, prev_tx}, 128'd0);
            if (rx_state) begin
                n_rx_state++;
                check("rx_state_single", {127'd0, prev_rs}, 128'd0);
            end
            if (rx_overrun) begin
                n_overrun++;
                check("rx_overrun_single", {127'd0, prev_ov}, 128'd0);
            end
            prev_tx = tx_start; prev_rs = rx_state; prev_ov = rx_overrun; prev_busy = tx_busy;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        rx_byte = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [0:127] blk);
        for (int k = 0; k < 16; k++) send_byte(blk[8*k +: 8]);
    endtask

    task automatic push_pt(input int nbytes);
        for (int k = 0; k < nbytes; k++) exp_q.push_back(8'(k * 17));
    endtask

    task automatic wait_done(input string name, input int limit);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {127'd0, ok}, 128'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int rs0, target;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_key", key, 128'd0);
        check("reset_data", data, 128'd0);
        check("reset_key_loaded", {127'd0, key_loaded}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_strobes", {125'd0, tx_start, rx_state, rx_overrun}, 128'd0);
        check("reset_tx_byte", {120'd0, tx_byte}, 128'd0);
        @(posedge clk);
        #1;

        // 1: FIPS-197 end to end
        send_block(FIPS_KEY);
        @(negedge clk);
        check("key_loaded_after_key", {127'd0, key_loaded}, 128'd1);
        check("key_value", key, FIPS_KEY);
        @(posedge clk);
        #1;
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t1_done", 500);
        check("t1_rx_state_count", 128'(n_rx_state), 128'd1);
        check("t1_data", data, FIPS_CT);

        // 2: back-to-back blocks
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t2a_done", 500);
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t2b_done", 500);
        check("t2_rx_state_count", 128'(n_rx_state), 128'd3);
        check("t2_key_loaded", {127'd0, key_loaded}, 128'd1);

        // 3: overrun while the core is slow
        core_lat = 50;
        push_pt(16);
        send_block(FIPS_CT);
        send_byte(8'hAA);
        check("t3_overrun_count", 128'(n_overrun), 128'd1);
        check("t3_data_unchanged", data, FIPS_CT);
        wait_done("t3a_done", 500);
        core_lat = 1;
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t3b_done", 500);
        check("t3_rx_state_count", 128'(n_rx_state), 128'd5);

        // 4: idle timeout discards a partial block
        rs0 = n_rx_state;
        for (int k = 1; k <= 5; k++) send_byte(8'(k * 17));
        repeat (25) @(posedge clk);
        #1;
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t4_done", 500);
        check("t4_one_decrypt", 128'(n_rx_state - rs0), 128'd1);
        check("t4_no_overrun", 128'(n_overrun), 128'd1);

        // 5: transmitter back-pressure
        busy_len = 10;
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t5_done", 1000);
        busy_len = 2;

        // 6: reset after the 7th tx_start
        target = n_tx + 7;
        push_pt(7);
        send_block(FIPS_CT);
        for (int i = 0; i < 500 && n_tx < target; i++) @(negedge clk);
        check("t6_seventh_tx_seen", {127'd0, n_tx >= target}, 128'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_key_cleared", key, 128'd0);
        check("t6_data_cleared", data, 128'd0);
        check("t6_key_loaded", {127'd0, key_loaded}, 128'd0);
        check("t6_busy", {127'd0, busy}, 128'd0);
        check("t6_strobes", {125'd0, tx_start, rx_state, rx_overrun}, 128'd0);
        check("t6_tx_byte", {120'd0, tx_byte}, 128'd0);
        check("t6_queue_drained", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
        send_block(FIPS_KEY);
        @(negedge clk);
        check("t6_key_reloaded", {127'd0, key_loaded}, 128'd1);
        @(posedge clk);
        #1;
        push_pt(16);
        send_block(FIPS_CT);
        wait_done("t6_done", 500);

        check("final_rx_state_count", 128'(n_rx_state), 128'd9);
        check("final_overrun_count", 128'(n_overrun), 128'd1);
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_uart_dec_ctrl.md
# aes_uart_dec_ctrl

Byte-level sequencer between the UART receiver/transmitter and the AES-128 decryption core (`decryption_main`). It assembles the first 16 received bytes into the 128-bit key and each following 16 bytes into a ciphertext block. It launches the core with a one-cycle `rx_state` strobe, captures the plaintext on `decrypted_data_state`, and streams the 16 plaintext bytes back out through the UART transmitter.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles with no `rx_valid` before a partial key or block is discarded. Set to 0 to disable.
- `clk` in 1: system clock. Everything is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx_byte` in 8: byte from the UART receiver.
- `rx_valid` in 1: one-cycle strobe; `rx_byte` is valid in this cycle.
- `key` out [0:127]: key to the decryption core. Holds its value until reset.
- `data` out [0:127]: ciphertext block to the decryption core.
- `rx_state` out 1: one-cycle start strobe to the decryption core.
- `decrypted_data` in [0:127]: plaintext from the decryption core.
- `decrypted_data_state` in 1: core done. Sampled only in WAIT_DEC.
- `tx_byte` out 8: byte to the UART transmitter.
- `tx_start` out 1: one-cycle transmit request.
- `tx_busy` in 1: the UART transmitter is shifting.
- `key_loaded` out 1: high once a full key has been captured.
- `busy` out 1: high in START, WAIT_DEC, SEND and SEND_WAIT.
- `rx_overrun` out 1: one-cycle pulse when an `rx_valid` byte is dropped.

## Operation
- **Byte order:** byte k (k = 0..15, in arrival order) maps to bits [8k : 8k+7]. The first byte lands in [0:7]. Transmit order is the same: [0:7] is sent first.
- **Byte counter:** `cnt` is 4 bits. It wraps 15 → 0 on block completion.
- **LOAD_KEY** (reset state):
  - Each `rx_valid` writes the byte into key lane `cnt` and increments `cnt`.
  - On the byte where `cnt` = 15: set `key_loaded`, `cnt` → 0, go to LOAD_DATA.
- **LOAD_DATA:**
  - Each `rx_valid` writes the byte into data lane `cnt` and increments `cnt`.
  - On the byte where `cnt` = 15: `cnt` → 0, go to START.
- **START:** `rx_state` = 1 for exactly this cycle. Go to WAIT_DEC.
- **WAIT_DEC:** when `decrypted_data_state` = 1, latch `decrypted_data` into the tx shift register, set `cnt` = 0, go to SEND. Otherwise stay.
- **SEND:** when `tx_busy` = 0, drive `tx_start` = 1 with `tx_byte` = lane `cnt`, then go to SEND_WAIT.
- **SEND_WAIT:**
  - The cycle right after `tx_start` is a guard cycle; `tx_busy` is ignored.
  - After the guard cycle, wait for `tx_busy` = 0.
  - Then: if `cnt` = 15, set `cnt` = 0 and go to LOAD_DATA; otherwise increment `cnt` and go to SEND.
- **Dropped bytes:** `rx_valid` in START, WAIT_DEC, SEND or SEND_WAIT drops the byte and pulses `rx_overrun` in the next cycle. Registers are not modified.
- **Idle timeout:**
  - An idle counter counts cycles without `rx_valid` while in LOAD_KEY or LOAD_DATA with `cnt` ≠ 0. It clears on any `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`: `cnt` → 0 and the state is unchanged. Previously written lanes are kept but will be overwritten.
  - In LOAD_KEY, `key_loaded` stays 0 after a timeout.
- **Reset:**
  - Reset values: all outputs 0, `key` = 0, `data` = 0, `cnt` = 0, idle counter = 0, state = LOAD_KEY.
  - `rst` wins over every simultaneous event, including `rx_valid` and `decrypted_data_state`.
  - Reset mid-block or mid-transmit abandons the operation. A new key must be loaded.

## Timing
- **Start latency:** the 16th data byte's `rx_valid` in cycle N → `data` complete and `rx_state` = 1 in cycle N+1 → WAIT_DEC from N+2.
- **Result capture:** `decrypted_data_state` = 1 in cycle M → plaintext latched at the end of M. The first `tx_start` is in M+1 if `tx_busy` = 0.
- **Transmit spacing:** consecutive `tx_start` pulses are at least 3 cycles apart (SEND, guard, at least one SEND_WAIT cycle).
- **Key completion:** the 16th key byte in cycle K → `key_loaded` = 1 from K+1. The next `rx_valid` in K+1 is accepted as data byte 0.
- `rx_state`, `tx_start` and `rx_overrun` are each never high for two consecutive cycles.
- `key` and `data` are stable from START until the return to LOAD_DATA.

## Test plan
1. **FIPS-197 end to end:**
   - Stimulus: key bytes 00 01 … 0f, then ciphertext 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, with the real core attached.
   - Required: exactly one `rx_state` pulse, then 16 `tx_start` pulses carrying 00 11 22 … ff in order.
2. **Back-to-back blocks:** after test 1, send the same ciphertext twice → 32 output bytes, `key_loaded` stays 1, no extra `rx_state` pulses.
3. **Overrun:**
   - Stimulus: send byte 0xAA while the core stub holds `decrypted_data_state` = 0 for 50 cycles.
   - Required: `rx_overrun` pulses once, `data` is unchanged, and the next block decrypts correctly.
4. **Timeout:** with `TIMEOUT_CYCLES` = 20, send 5 data bytes, idle 25 cycles, then send 16 bytes → exactly one decrypt, using the last 16 bytes.
5. **Transmitter back-pressure:** stub holds `tx_busy` = 1 for 10 cycles after every `tx_start` → each `tx_start` comes at least 1 cycle after `tx_busy` falls, and bytes are in order.
6. **Reset mid-transmit:** assert `rst` after the 7th `tx_start` → all outputs 0 next cycle, `key_loaded` = 0, and the block re-enters LOAD_KEY.
